// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares a single-port instruction memory between the fetch stage (read-only)
// and a debug/program-loader port (read/write). One memory transaction is in
// flight at a time. Debug has priority, and a starvation guard forces fetch
// to win after STARVE_LIMIT consecutive lost arbitrations. A fetch response
// can be discarded after a branch redirect via flush_i.
//
// Transaction flow: IDLE (arbitrate, latch m_* registers) -> REQ (m_req_o
// held until m_gnt_i, owner gnt pulses) -> WAIT (owner rvalid pulses on
// m_rvalid_i) -> IDLE.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   f_req_i, f_addr_i          fetch read request and address
//   f_gnt_o                    fetch request accepted (1-cycle pulse)
//   f_rvalid_o, f_rdata_o      fetch read response
//   flush_i                    drop the response of the in-flight fetch
//   d_req_i, d_we_i,
//   d_addr_i, d_wdata_i        debug request, write enable, address, data
//   d_gnt_o                    debug request accepted (1-cycle pulse)
//   d_rvalid_o, d_rdata_o      debug response (read data or write ack)
//   m_req_o, m_we_o,
//   m_addr_o, m_wdata_o        registered memory request
//   m_gnt_i                    memory accepted the request
//   m_rvalid_i, m_rdata_i      memory response
//
// Optional feature (macro IMEM_ARB_PERF_CNT_EN):
//   perf_f_stall_o [31:0]      cycles with f_req_i=1 and f_gnt_o=0
//   perf_d_xact_o  [31:0]      number of d_gnt_o pulses
//   Both reset to 0 and wrap. Without the macro these ports do not exist.
// -----------------------------------------------------------------------------

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module imem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = `DATA_WIDTH,
    parameter int DATA_W       = `INSTR_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    input  logic              flush_i,
    // debug port
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    // memory port
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic              m_gnt_i,
    input  logic              m_rvalid_i,
    input  logic [DATA_W-1:0] m_rdata_i
`ifdef IMEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_f_stall_o,
    output logic [31:0]       perf_d_xact_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_F = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // A zero limit disables the guard; the counter then stays at 0.
    localparam int              CNT_W    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam bit              GUARD_EN = (STARVE_LIMIT != 0);

    state_e            state_q;
    owner_e            owner_q;
    logic              drop_q;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    logic              m_req_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;

    logic force_f;
    logic pick_d;
    logic pick_f;
    logic owner_is_f;

    // Arbitration: debug wins unless fetch has lost STARVE_LIMIT times in a row.
    assign force_f    = GUARD_EN && (starve_q == LIMIT_C) && f_req_i;
    assign pick_d     = d_req_i && !force_f;
    assign pick_f     = f_req_i && !pick_d;
    assign owner_is_f = (owner_q == OWNER_F);

    // Saturating count of arbitrations that fetch lost to debug.
    always_comb begin
        starve_d = starve_q;
        if (pick_f) begin
            starve_d = '0;
        end else if (pick_d && f_req_i && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_F;
            drop_q    <= 1'b0;
            starve_q  <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // m_rvalid_i is deliberately ignored here: a late response
                    // from an aborted transaction must not leak out.
                    if (pick_d || pick_f) begin
                        state_q   <= REQ;
                        m_req_q   <= 1'b1;
                        owner_q   <= pick_d ? OWNER_D : OWNER_F;
                        m_addr_q  <= pick_d ? d_addr_i : f_addr_i;
                        m_we_q    <= pick_d && d_we_i;
                        m_wdata_q <= pick_d ? d_wdata_i : '0;
                        starve_q  <= starve_d;
                    end
                end
                REQ: begin
                    if (flush_i && owner_is_f) begin
                        drop_q <= 1'b1;
                    end
                    if (m_gnt_i) begin
                        state_q <= WAIT;
                        m_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (m_rvalid_i) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                    end else if (flush_i && owner_is_f) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    m_req_q <= 1'b0;
                    drop_q  <= 1'b0;
                end
            endcase
        end
    end

    assign m_req_o   = m_req_q;
    assign m_we_o    = m_we_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;

    // Grants and responses are combinational so the owner sees them in the
    // same cycle as the memory handshake.
    assign f_gnt_o = (state_q == REQ) && m_gnt_i && owner_is_f;
    assign d_gnt_o = (state_q == REQ) && m_gnt_i && !owner_is_f;

    // A flush arriving together with the response suppresses it as well.
    assign f_rvalid_o = (state_q == WAIT) && m_rvalid_i && owner_is_f && !drop_q && !flush_i;
    assign d_rvalid_o = (state_q == WAIT) && m_rvalid_i && !owner_is_f;

    // Read data is forced to 0 when not valid so idle outputs are deterministic.
    assign f_rdata_o = f_rvalid_o ? m_rdata_i : '0;
    assign d_rdata_o = d_rvalid_o ? m_rdata_i : '0;

`ifdef IMEM_ARB_PERF_CNT_EN
    logic [31:0] perf_f_stall_q;
    logic [31:0] perf_d_xact_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_f_stall_q <= '0;
            perf_d_xact_q  <= '0;
        end else begin
            if (f_req_i && !f_gnt_o) begin
                perf_f_stall_q <= perf_f_stall_q + 32'd1;
            end
            if (d_gnt_o) begin
                perf_d_xact_q <= perf_d_xact_q + 32'd1;
            end
        end
    end

    assign perf_f_stall_o = perf_f_stall_q;
    assign perf_d_xact_o  = perf_d_xact_q;
`endif

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the fetch stage (read-only) and a debug/program-loader port (read/write).
- One outstanding memory transaction at a time, using a request/grant + response-valid protocol.
- Debug has priority, with a starvation guard for fetch.
- Sits between the fetch/loader logic and the instruction memory. Supports flushing a fetch response after a branch redirect.

Parameters:
- STARVE_LIMIT, 8: consecutive losing cycles of fetch before fetch is forced to win the next arbitration; 0 = pure debug priority (guard disabled).
- ADDR_W, `DATA_WIDTH (32): address width.
- DATA_W, `INSTR_WIDTH (32): data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- f_req_i  in  1  fetch read request; held with f_addr_i stable until f_gnt_o
- f_addr_i  in  ADDR_W  fetch address
- f_gnt_o  out  1  fetch request accepted by memory (1-cycle pulse)
- f_rvalid_o  out  1  fetch read data valid (1-cycle pulse)
- f_rdata_o  out  DATA_W  fetch read data
- flush_i  in  1  discard response of the in-flight fetch transaction
- d_req_i  in  1  debug request; held with address/we/wdata stable until d_gnt_o
- d_we_i  in  1  debug write enable
- d_addr_i  in  ADDR_W  debug address
- d_wdata_i  in  DATA_W  debug write data
- d_gnt_o  out  1  debug request accepted (1-cycle pulse)
- d_rvalid_o  out  1  debug response valid (read data, or write ack)
- d_rdata_o  out  DATA_W  debug read data
- m_req_o  out  1  memory request
- m_we_o  out  1  memory write enable
- m_addr_o  out  ADDR_W  memory address
- m_wdata_o  out  DATA_W  memory write data
- m_gnt_i  in  1  memory accepted request
- m_rvalid_i  in  1  memory response valid (read data or write ack); never in the same cycle as its m_gnt_i
- m_rdata_i  in  DATA_W  memory read data

Behaviour:
- Clocking/reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; owner, drop flag and starvation counter = 0.
  - m_req_o, m_we_o, m_addr_o, m_wdata_o = 0.
  - All gnt_o/rvalid_o = 0; rdata outputs = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any request is pending, pick the winner; latch owner, addr, we (forced 0 for fetch), wdata into the m_* registers; go to REQ. m_req_o is registered, high the cycle after arbitration.
  - m_rvalid_i is ignored in IDLE.
- Arbitration:
  - Debug wins if d_req_i, unless the starve counter equals STARVE_LIMIT (and STARVE_LIMIT≠0); then fetch wins if f_req_i.
  - Starve counter increments (saturating at STARVE_LIMIT) each IDLE arbitration where f_req_i=1 and debug wins. It clears when fetch is granted.
- REQ:
  - m_req_o=1 and held stable until m_gnt_i.
  - On m_gnt_i: owner's gnt_o = 1 combinationally that cycle; next state is WAIT; m_req_o drops next cycle.
- WAIT:
  - On m_rvalid_i: owner's rvalid_o = 1 and rdata_o = m_rdata_i, combinational, one cycle; next state is IDLE.
  - Non-owner rvalid_o stays 0.
  - Debug write completes via d_rvalid_o, with d_rdata_o = m_rdata_i (don't care).
- Flush:
  - flush_i=1 while owner=fetch in REQ or WAIT sets the drop flag.
  - The request still completes on the memory side, but f_rvalid_o is suppressed for that response; drop clears on return to IDLE.
  - flush_i in IDLE, or with owner=debug, has no effect.
  - flush_i in the same cycle as m_rvalid_i (owner=fetch) suppresses that cycle's f_rvalid_o.
- Throughput/latency:
  - One bubble cycle in IDLE between transactions.
  - Minimum request-to-response latency is 3 cycles for a 1-cycle memory: arbitrate N, grant N+1, response N+2.
  - Best throughput is one transaction per 3 cycles.
- Simultaneous requests: exactly one is granted; the loser keeps its request asserted and is re-arbitrated next IDLE.
- Reset mid-operation: returns to IDLE immediately. No gnt or rvalid is generated for the aborted transaction; a late m_rvalid_i is ignored.

Optional Feature:
- Macro IMEM_ARB_PERF_CNT_EN.
- When defined, adds two outputs; both reset to 0 and wrap on overflow:
  - perf_f_stall_o [31:0]: counts cycles with f_req_i=1 and f_gnt_o=0.
  - perf_d_xact_o [31:0]: counts d_gnt_o pulses.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Fetch only: f_req_i=1, addr 0x0000_0010, memory grants immediately with 1-cycle response 0x00500093 → f_gnt_o pulses; f_rvalid_o pulses 3 cycles after request, f_rdata_o=0x00500093; d_* outputs stay 0.
- Debug write then read: d_we_i=1, addr 0x20, wdata 0xDEADBEEF, then a read of 0x20 → m_we_o=1 with m_wdata_o=0xDEADBEEF; d_rvalid_o ack; read returns d_rdata_o=0xDEADBEEF.
- Starvation: STARVE_LIMIT=2, d_req_i and f_req_i held continuously → grant order debug, debug, fetch, debug, debug, fetch.
- Flush: fetch to 0x40 granted, flush_i pulsed during WAIT with 3-cycle memory latency → m_rvalid_i seen but f_rvalid_o stays 0; next fetch to 0x80 returns normally.
- Backpressure: m_gnt_i held 0 for 5 cycles → m_req_o, m_addr_o, m_we_o stable all 5 cycles, no gnt_o; grant on cycle 6.
- Reset in WAIT: rst_n low for 1 cycle, then a stray m_rvalid_i → no rvalid_o, state IDLE; a fresh f_req_i then completes normally; with IMEM_ARB_PERF_CNT_EN, counters read 0 after reset.
